// File: rtl/rv_pipe_pkg.sv
// rv_pipe_pkg: shared widths, NOP encoding and fetch FSM states for the pipeline
package rv_pipe_pkg;
  localparam int XLEN = 64;
  localparam int ILEN = 32;
  localparam logic [31:0] INST_NOP = 32'h0000_0013;
  typedef enum logic [2:0] {BOOT, FETCH, WAIT, HOLD, DRAIN} fetch_state_t;
endpackage

// File: rtl/if_hold_buf.sv
// if_hold_buf: single-entry {inst, pc} park register for a word fetched during a stall
module if_hold_buf #(
  parameter int XLEN = rv_pipe_pkg::XLEN,
  parameter int ILEN = rv_pipe_pkg::ILEN
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            clear,
  input  logic [ILEN-1:0] inst_in,
  input  logic [XLEN-1:0] pc_in,
  output logic [ILEN-1:0] inst,
  output logic [XLEN-1:0] pc
);
  // park the word on load, drop it on clear
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      inst <= '0;
      pc   <= '0;
    end else if (clear) begin
      inst <= '0;
      pc   <= '0;
    end else if (load) begin
      inst <= inst_in;
      pc   <= pc_in;
    end
endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: IF-stage fetch sequencer feeding the IF/ID register from a variable-latency imem
module if_fetch_unit #(
  parameter int XLEN = rv_pipe_pkg::XLEN,
  parameter int ILEN = rv_pipe_pkg::ILEN,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [ILEN-1:0] imem_rdata,
  output logic [ILEN-1:0] instruction,
  output logic [XLEN-1:0] pc,
  output logic            ifid_write,
  output logic            flush
);
  import rv_pipe_pkg::*;
  fetch_state_t state, state_nxt;
  logic [XLEN-1:0] fetch_pc, target, hb_pc;
  logic [ILEN-1:0] hb_inst;
  logic hb_load, hb_clear, wr_wait, wr_hold;
  assign target = redirect_pc & ~{{(XLEN-2){1'b0}}, 2'b11};
  if_hold_buf #(.XLEN(XLEN), .ILEN(ILEN)) u_hold (
    .clk(clk), .reset(reset), .load(hb_load), .clear(hb_clear),
    .inst_in(imem_rdata), .pc_in(fetch_pc), .inst(hb_inst), .pc(hb_pc)
  );
  // state and fetch PC; a redirect always wins, otherwise advance on each IF/ID write
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state    <= BOOT;
      fetch_pc <= RESET_PC;
    end else begin
      state    <= state_nxt;
      fetch_pc <= redirect_valid ? target : ifid_write ? fetch_pc + XLEN'(4) : fetch_pc;
    end
  // next state; a redirect with a request in flight must drain its response first
  always_comb begin
    state_nxt = state;
    case (state)
      BOOT:    state_nxt = FETCH;
      FETCH:   state_nxt = imem_gnt ? (redirect_valid ? DRAIN : WAIT) : FETCH;
      WAIT:    state_nxt = imem_rvalid ? ((stall && !redirect_valid) ? HOLD : FETCH)
                                       : (redirect_valid ? DRAIN : WAIT);
      HOLD:    state_nxt = (redirect_valid || !stall) ? FETCH : HOLD;
      DRAIN:   state_nxt = imem_rvalid ? FETCH : DRAIN;
      default: state_nxt = BOOT;
    endcase
  end
  // outputs and hold-buffer control; stray rvalid outside WAIT/DRAIN has no effect
  always_comb begin
    wr_wait     = state == WAIT && imem_rvalid && !stall && !redirect_valid;
    wr_hold     = state == HOLD && !stall && !redirect_valid;
    imem_req    = state == FETCH;
    imem_addr   = fetch_pc;
    flush       = redirect_valid && state != BOOT;
    ifid_write  = wr_wait || wr_hold;
    instruction = wr_wait ? imem_rdata : wr_hold ? hb_inst : '0;
    pc          = wr_wait ? fetch_pc : wr_hold ? hb_pc : '0;
    hb_load     = state == WAIT && imem_rvalid && stall && !redirect_valid;
    hb_clear    = state == HOLD && (redirect_valid || !stall);
  end
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed checks of fetch, stall parking, redirects, PC wrap and mid-run reset
module tb_if_fetch_unit;
  logic        clk, reset, stall, redirect_valid, imem_gnt, imem_rvalid;
  logic [63:0] redirect_pc, imem_addr, pc;
  logic [31:0] imem_rdata, instruction;
  logic        imem_req, ifid_write, flush;
  int checks = 0;
  int errors = 0;
  if_fetch_unit dut (
    .clk(clk), .reset(reset), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instruction(instruction), .pc(pc), .ifid_write(ifid_write), .flush(flush)
  );
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic drive(input logic g, input logic rv, input logic [31:0] rd, input logic st,
                       input logic rdv, input logic [63:0] rdpc);
    @(negedge clk);
    imem_gnt = g; imem_rvalid = rv; imem_rdata = rd; stall = st;
    redirect_valid = rdv; redirect_pc = rdpc;
    #1;
  endtask
  task automatic chk_req(input string tag, input logic r, input logic [63:0] a);
    chk({tag, "_req"}, 64'(imem_req), 64'(r));
    if (r) chk({tag, "_addr"}, imem_addr, a);
  endtask
  task automatic chk_wr(input string tag, input logic w, input logic [63:0] p, input logic [31:0] i);
    chk({tag, "_wr"}, 64'(ifid_write), 64'(w));
    chk({tag, "_fl"}, 64'(flush), 64'(0));
    if (w) begin
      chk({tag, "_pc"}, pc, p);
      chk({tag, "_inst"}, 64'(instruction), 64'(i));
    end
  endtask
  initial begin
    reset = 0; stall = 0; redirect_valid = 0; redirect_pc = '0;
    imem_gnt = 0; imem_rvalid = 0; imem_rdata = '0;
    #2;
    chk("rst_req", 64'(imem_req), 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_inst", 64'(instruction), 0);
    chk("rst_pc", pc, 0);
    chk("rst_wr", 64'(ifid_write), 0);
    chk("rst_flush", 64'(flush), 0);
    @(negedge clk); reset = 1;
    drive(1, 0, 0, 0, 0, 0);           chk_req("t1_f0", 1, 64'h0);
    drive(0, 1, 32'h00500093, 0, 0, 0); chk_req("t1_w0", 0, 0); chk_wr("t1_w0", 1, 64'h0, 32'h00500093);
    drive(1, 0, 0, 0, 0, 0);           chk_req("t1_f4", 1, 64'h4); chk_wr("t1_f4", 0, 0, 0);
    drive(0, 1, 32'h11111111, 0, 0, 0); chk_wr("t2_w4", 1, 64'h4, 32'h11111111);
    drive(1, 0, 0, 0, 0, 0);           chk_req("t2_f8", 1, 64'h8);
    drive(0, 1, 32'hDEADBEEF, 1, 0, 0); chk_wr("t2_stall_rv", 0, 0, 0);
    drive(0, 0, 0, 1, 0, 0);           chk_wr("t2_hold", 0, 0, 0); chk_req("t2_hold", 0, 0);
    drive(0, 0, 0, 0, 0, 0);           chk_wr("t2_release", 1, 64'h8, 32'hDEADBEEF);
    drive(1, 0, 0, 0, 0, 0);           chk_req("t2_f12", 1, 64'hC); chk_wr("t2_f12", 0, 0, 0);
    drive(0, 0, 0, 0, 1, 64'h100);
    chk("t3_flush", 64'(flush), 1); chk("t3_wr", 64'(ifid_write), 0);
    drive(0, 1, 32'h0BAD0BAD, 0, 0, 0); chk_wr("t3_drain", 0, 0, 0); chk_req("t3_drain", 0, 0);
    drive(1, 0, 0, 0, 0, 0);           chk_req("t3_f100", 1, 64'h100); chk_wr("t3_f100", 0, 0, 0);
    drive(0, 1, 32'h0000CAFE, 1, 0, 0); chk_wr("t4_stall_rv", 0, 0, 0);
    drive(0, 0, 0, 1, 1, 64'h300);
    chk("t4_flush", 64'(flush), 1); chk("t4_wr", 64'(ifid_write), 0);
    drive(0, 0, 0, 0, 0, 0);           chk_wr("t4_no_held", 0, 0, 0); chk_req("t4_f300", 1, 64'h300);
    drive(0, 0, 0, 0, 1, 64'h203);    chk("t5_flush", 64'(flush), 1);
    drive(0, 0, 0, 0, 0, 0);           chk_req("t5_align", 1, 64'h200);
    drive(0, 0, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFF);
    drive(1, 0, 0, 0, 0, 0);           chk_req("t5_top", 1, 64'hFFFF_FFFF_FFFF_FFFC);
    drive(0, 1, 32'h00000013, 0, 0, 0); chk_wr("t5_top", 1, 64'hFFFF_FFFF_FFFF_FFFC, 32'h00000013);
    drive(1, 0, 0, 0, 0, 0);           chk_req("t5_wrap", 1, 64'h0);
    drive(0, 1, 32'h00000022, 0, 0, 0); chk_wr("t6_w0", 1, 64'h0, 32'h00000022);
    drive(1, 0, 0, 0, 0, 0);           chk_req("t6_f4", 1, 64'h4);
    @(negedge clk); imem_gnt = 0; reset = 0; #1;
    chk_req("t6_rst", 0, 0); chk("t6_rst_addr", imem_addr, 0); chk_wr("t6_rst", 0, 0, 0);
    chk("t6_rst_inst", 64'(instruction), 0); chk("t6_rst_pc", pc, 0);
    @(negedge clk); reset = 1; imem_rvalid = 1; imem_rdata = 32'h00000077; #1;
    chk_wr("t6_late_boot", 0, 0, 0);
    drive(0, 1, 32'h00000077, 0, 0, 0); chk_wr("t6_late_fetch", 0, 0, 0); chk_req("t6_restart", 1, 64'h0);
    drive(1, 0, 0, 0, 0, 0);           chk_req("t6_f0", 1, 64'h0);
    drive(0, 1, 32'h00000099, 0, 0, 0); chk_wr("t6_w0b", 1, 64'h0, 32'h00000099);
    drive(0, 0, 0, 0, 0, 0);           chk_req("t6_f4b", 1, 64'h4);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
